// File: rtl/fir_decim_fifo.sv
// Decimator (pick, or boxcar average with FIR_DECIM_AVG_EN) feeding a FWFT FIFO; result visible 1 cycle after its event.
// Upstream is never stalled: pushes into a full FIFO without a same-cycle pop are dropped and set sticky overflow.
module fir_decim_fifo #(
  parameter int DW    = 12,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clr,
  input  logic signed [DW-1:0]         in,
  output logic signed [DW-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int LG = $clog2(DECIM);
  localparam int PW = (LG > 0) ? LG : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]        phase;
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count_nxt;
  logic signed [DW-1:0] mem [DEPTH];
  logic signed [DW-1:0] result;
  logic                 ev, pop, push, full;

  assign ev = en && (phase == PW'(DECIM-1));

`ifdef FIR_DECIM_AVG_EN
  logic signed [DW+LG-1:0] acc, sum;

  assign sum    = acc + (DW+LG)'(in);
  assign result = DW'(sum >>> LG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= ev ? '0 : sum;
  end
`else
  assign result = in;
`endif

  always_comb begin
    full      = (count == CW'(DEPTH));
    pop       = out_valid && out_ready;
    push      = ev && (!full || pop);
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      phase     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (en)          phase    <= ev ? '0 : phase + PW'(1);
      if (ev && !push) overflow <= 1'b1;
      if (push)        wr_ptr   <= wr_ptr + AW'(1);
      if (pop)         rd_ptr   <= rd_ptr + AW'(1);
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      // Head register: refilled from memory on pop, or bypassed from result when the FIFO is (becoming) empty.
      if (pop) begin
        if (count > CW'(1)) out_data <= mem[rd_ptr + AW'(1)];
        else if (push)      out_data <= result;
      end else if (push && count == '0) begin
        out_data <= result;
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: directed table, hand sequences, and random traffic against a queue-based model.
module tb_fir_decim_fifo;
  localparam int DW    = 12;
  localparam int D     = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic signed [DW-1:0] in_s = '0;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic [CW-1:0]        count;
  logic                 overflow;

  int nchk = 0, nerr = 0;
  int q[$];
  bit movf;
  int ecnt, gsum;

  fir_decim_fifo #(.DW(DW), .DECIM(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in(in_s),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: samples of a group are collected; the group's result is its last sample or its floored mean.
  function automatic int grp_result(input int last, input int sum);
    int r;
`ifdef FIR_DECIM_AVG_EN
    r = sum / D;
    if ((sum % D) != 0 && sum < 0) r = r - 1;
`else
    r = last;
`endif
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    movf = 0;
    ecnt = 0;
    gsum = 0;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".valid"}, int'(out_valid), (q.size() > 0) ? 1 : 0);
    chk({nm, ".count"}, int'(count), q.size());
    chk({nm, ".ovf"}, int'(overflow), int'(movf));
    if (q.size() > 0) chk({nm, ".data"}, int'(out_data), q[0]);
  endtask

  task automatic cyc(input bit e, input bit c, input bit r, input int d);
    bit pop, full;
    @(negedge clk);
    en = e; clr = c; out_ready = r; in_s = DW'(d);
    pop  = (q.size() > 0) && r;
    full = (q.size() == DEPTH);
    if (c) begin
      model_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (e) begin
        gsum += d;
        ecnt++;
        if (ecnt == D) begin
          if (!full || pop) q.push_back(grp_result(d, gsum));
          else movf = 1;
          ecnt = 0;
          gsum = 0;
        end
      end
    end
    @(posedge clk); #1;
    chk_model("model");
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".valid"}, int'(out_valid), 0);
    chk({nm, ".count"}, int'(count), 0);
    chk({nm, ".ovf"}, int'(overflow), 0);
    chk({nm, ".data"}, int'(out_data), 0);
  endtask

  task automatic hard_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0; clr = 1'b0; out_ready = 1'b0;
  endtask

  task automatic group(input int v, input bit rdy_last);
    for (int k = 0; k < D; k++) cyc(1, 0, (k == D-1) ? rdy_last : 1'b0, v);
  endtask

  typedef struct {
    bit e;
    bit r;
    int d;
    bit exp_vld;
    int exp_data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    model_reset();
`ifdef FIR_DECIM_AVG_EN
    tbl[0] = '{1, 1, 10, 0, 0};  tbl[1] = '{1, 1, 11, 0, 0};
    tbl[2] = '{1, 1, 12, 0, 0};  tbl[3] = '{1, 1, 13, 1, 11};
    tbl[4] = '{1, 1, -1, 0, 0};  tbl[5] = '{1, 1, -2, 0, 0};
    tbl[6] = '{1, 1, -2, 0, 0};  tbl[7] = '{1, 1, -2, 1, -2};
`else
    for (int i = 0; i < 8; i++) tbl[i] = '{1, 1, i, (i % 4 == 3), i};
`endif
    #1 chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].e, 0, tbl[i].r, tbl[i].d);
      chk($sformatf("tbl%0d.valid", i), int'(out_valid), int'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d.count", i), int'(count), int'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) chk($sformatf("tbl%0d.data", i), int'(out_data), tbl[i].exp_data);
    end

    // Fill to full, then a pop+push on the full FIFO, then a genuine overflow.
    hard_reset();
    for (int g = 0; g < 8; g++) begin
      group(20 + g, 0);
      chk($sformatf("fill%0d.count", g), int'(count), g + 1);
      chk($sformatf("fill%0d.ovf", g), int'(overflow), 0);
    end
    group(28, 1);
    chk("full_poppush.count", int'(count), 8);
    chk("full_poppush.ovf", int'(overflow), 0);
    chk("full_poppush.head", int'(out_data), 21);
    group(29, 0);
    chk("overflow.count", int'(count), 8);
    chk("overflow.ovf", int'(overflow), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0);
      chk($sformatf("drain%0d.head", k), int'(out_data), 22 + k);
    end
    chk("drain.count", int'(count), 5);
    chk("drain.ovf", int'(overflow), 1);

    // clr beats a same-cycle push and restarts the phase.
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 50);
    cyc(1, 1, 0, 50);
    chk("clr.count", int'(count), 0);
    chk("clr.valid", int'(out_valid), 0);
    chk("clr.ovf", int'(overflow), 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 60);
    chk("clr_phase.count3", int'(count), 0);
    cyc(1, 0, 0, 60);
    chk("clr_phase.count4", int'(count), 1);
    chk("clr_phase.data", int'(out_data), 60);

    // Reset mid-group discards the partial group and the FIFO.
    cyc(1, 0, 0, 70);
    cyc(1, 0, 0, 70);
    hard_reset();
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 80);
    chk("rst_phase.count3", int'(count), 0);
    cyc(1, 0, 0, 80);
    chk("rst_phase.count4", int'(count), 1);
    chk("rst_phase.data", int'(out_data), 80);

    // Random traffic.
    hard_reset();
    for (int n = 0; n < 3000; n++) begin
      int v;
      v = int'($urandom_range(0, 4095));
      if (v >= 2048) v = v - 4096;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 1) == 1, v);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fir_decim_fifo.md
# fir_decim_fifo

Decimating output stage that sits directly downstream of the FIR low-pass filter in the LPDAQ signal chain. It takes the filtered sample stream, keeps one result per DECIM input samples, and buffers those results in a small first-word-fall-through FIFO. A valid/ready handshake hands the buffered samples to the acquisition consumer. Overflow is reported through a sticky flag rather than by stalling the filter, because the filter cannot be back-pressured.

## Interface
Parameters:
- DW, 12, sample width; signed two's complement, same format as the FIR output.
- DECIM, 4, decimation ratio; power of two, 1..256.
- DEPTH, 8, FIFO depth in samples; power of two, 2..64.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  input sample strobe; in is sampled only when en=1.
- clr  input  1  synchronous clear; empties FIFO, zeroes phase/accumulator, clears overflow.
- in  input  DW  signed filtered sample from the FIR.
- out_data  output  DW  signed head-of-FIFO sample; meaningful only when out_valid=1.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both 1 (a pop).
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  output  1  sticky; a decimated sample was dropped.

## Operation
- Phase counter runs 0..DECIM-1. It advances on each en=1 cycle and wraps to 0 after DECIM-1.
- A decimation event is a cycle with en=1 and phase==DECIM-1. With DECIM=1, every en cycle is an event.
- At a decimation event, the result is the current in (pick mode). See Configuration for averaging mode.
- Push rule: the result is written at the tail if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
- Otherwise the result is dropped and overflow is set to 1. overflow stays 1 until rst_n or clr.
- Pop: when out_valid=1 and out_ready=1, the head advances on the next edge. out_ready while empty has no effect.
- Simultaneous push and pop: count is unchanged and the data order is preserved.
- count updates every edge: +1 on push only, −1 on pop only.
- Pointers wrap modulo DEPTH. Full/empty are derived from count, not from pointer equality.
- clr has priority over en, push and pop in the same cycle. The cycle after clr has count=0, out_valid=0, phase=0 and overflow=0.
- The phase counter keeps advancing while the FIFO is full. Drops never shift the decimation grid.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): out_valid=0, count=0, overflow=0, out_data=0, phase=0, accumulator=0.
- Reset asserted mid-operation discards all buffered data and the partial accumulation. The first event after release occurs on the DECIM-th en.
- Latency: a sample pushed at edge N into an empty FIFO gives out_valid=1 with that sample on out_data after edge N. That is one cycle after the event cycle.
- out_data changes only on a pop or on a push into an empty FIFO. It holds stable while out_valid=1 and out_ready=0.
- Throughput: one push and one pop per cycle maximum.
- The design is a single clock domain with no combinational path from in to out_data. out_valid and count are registered.

## Configuration
- Macro: FIR_DECIM_AVG_EN.
- Defined (boxcar averaging mode):
  - An accumulator of width DW+log2(DECIM) sums each sampled in while en=1.
  - At the event, result = (acc + in) >>> log2(DECIM), an arithmetic shift that truncates toward −∞.
  - The accumulator is then reloaded with 0.
  - The result always fits in DW bits, so no saturation is needed.
- Undefined (pick mode):
  - No accumulator is built.
  - The result is the in value present at the event cycle.

## Test plan
- Pick mode, DECIM=4, en=1 continuously, in=0,1,2,…, out_ready=1: out_data sequence is 3,7,11,…. Each sample appears one cycle after its event.
- Averaging mode, DECIM=4, in=10,11,12,13 then −1,−2,−2,−2: out_data=11, then −2 (−7>>>2).
- Fill, DECIM=1, out_ready=0, 10 en cycles: count reaches 8 and overflow=1 at the 9th en. Draining then yields samples 0..7 in order.
- Full with simultaneous pop and push: count stays 8, overflow stays 0, and the new sample lands last.
- clr asserted alongside a push while count=5 and overflow=1: next cycle count=0, out_valid=0, overflow=0, phase=0.
- rst_n pulsed low mid-group after 2 of 4 en cycles: all outputs return to their reset values. The next output comes after 4 fresh en cycles.
